// File: rtl/mux_sel_arbiter.sv
// Two-requester arbiter driving the select of a downstream 2:1 mux, with round-robin tie-break.
// Optional forced release after MAX_HOLD granted cycles when ARB_TIMEOUT_EN is defined.
module mux_sel_arbiter #(
    parameter int unsigned MAX_HOLD = 15
) (
    input  logic clk_in,
    input  logic rstn_in,
    input  logic req_a_in,
    input  logic req_b_in,
    input  logic done_in,
    output logic sel_out,
    output logic grant_a_out,
    output logic grant_b_out,
    output logic busy_out,
    output logic timeout_out
);

    // state | meaning
    // IDLE  | no grant held; sel_out keeps the last granted side
    // GNT_A | requester A owns the mux path (sel_out = 0)
    // GNT_B | requester B owns the mux path (sel_out = 1)
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        GNT_A = 2'b01,
        GNT_B = 2'b10
    } state_t;

    state_t state_q;
    state_t state_d;
    logic   last_b_q;
    logic   last_b_d;
    logic   sel_d;
    logic   timeout_d;
    logic   owner_req;
    logic   other_req;
    logic   normal_release;
    logic   forced_release;
    logic   release_now;
    logic   grant_entry;

    if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_hold
        $error("mux_sel_arbiter: MAX_HOLD must be within 2..255");
    end

`ifdef ARB_TIMEOUT_EN
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    logic [7:0] hold_cnt_q;
    logic [7:0] hold_cnt_d;

    // Counter value k means the owner is in its (k+1)-th granted cycle.
    assign forced_release = (state_q != IDLE) && (hold_cnt_q == HOLD_LAST);

    always_comb begin
        hold_cnt_d = hold_cnt_q;
        if (state_d == IDLE || grant_entry) begin
            hold_cnt_d = 8'd0;
        end else begin
            hold_cnt_d = hold_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rstn_in) begin
            hold_cnt_q <= 8'd0;
        end else begin
            hold_cnt_q <= hold_cnt_d;
        end
    end
`else
    assign forced_release = 1'b0;
`endif

    assign owner_req      = (state_q == GNT_B) ? req_b_in : req_a_in;
    assign other_req      = (state_q == GNT_B) ? req_a_in : req_b_in;
    assign normal_release = done_in || !owner_req;
    assign release_now    = (state_q != IDLE) && (normal_release || forced_release);

    always_comb begin
        state_d   = state_q;
        timeout_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_a_in && req_b_in) begin
                    state_d = last_b_q ? GNT_A : GNT_B;
                end else if (req_a_in) begin
                    state_d = GNT_A;
                end else if (req_b_in) begin
                    state_d = GNT_B;
                end
            end
            GNT_A: begin
                if (release_now) begin
                    if (req_b_in) begin
                        state_d = GNT_B;
                    end else if (req_a_in) begin
                        state_d = GNT_A;
                    end else begin
                        state_d = IDLE;
                    end
                    timeout_d = forced_release && !normal_release;
                end
            end
            GNT_B: begin
                if (release_now) begin
                    if (req_a_in) begin
                        state_d = GNT_A;
                    end else if (req_b_in) begin
                        state_d = GNT_B;
                    end else begin
                        state_d = IDLE;
                    end
                    timeout_d = forced_release && !normal_release;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A re-grant of the same side after a release counts as a fresh entry.
    assign grant_entry = (state_d != IDLE) && ((state_q == IDLE) || release_now);

    always_comb begin
        last_b_d = last_b_q;
        sel_d    = sel_out;
        if (grant_entry) begin
            last_b_d = (state_d == GNT_B);
        end
        if (state_d == GNT_A) begin
            sel_d = 1'b0;
        end else if (state_d == GNT_B) begin
            sel_d = 1'b1;
        end
    end

    // other_req only matters through the explicit per-state branches above.
    logic unused_other_req;
    assign unused_other_req = other_req;

    always_ff @(posedge clk_in) begin
        if (!rstn_in) begin
            state_q     <= IDLE;
            last_b_q    <= 1'b1;
            sel_out     <= 1'b0;
            grant_a_out <= 1'b0;
            grant_b_out <= 1'b0;
            busy_out    <= 1'b0;
            timeout_out <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_b_q    <= last_b_d;
            sel_out     <= sel_d;
            grant_a_out <= (state_d == GNT_A);
            grant_b_out <= (state_d == GNT_B);
            busy_out    <= (state_d != IDLE);
            timeout_out <= timeout_d;
        end
    end

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Self-checking bench for mux_sel_arbiter: directed scenarios plus randomized traffic
// compared every cycle against an owner/hold-count model of the arbitration rules.
module tb_mux_sel_arbiter;

    localparam int MAX_HOLD = 4;
`ifdef ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic clk_in = 1'b0;
    logic rstn_in = 1'b0;
    logic req_a_in = 1'b0;
    logic req_b_in = 1'b0;
    logic done_in = 1'b0;
    logic sel_out, grant_a_out, grant_b_out, busy_out, timeout_out;

    int n_cmp = 0;
    int n_err = 0;

    mux_sel_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk_in      (clk_in),
        .rstn_in     (rstn_in),
        .req_a_in    (req_a_in),
        .req_b_in    (req_b_in),
        .done_in     (done_in),
        .sel_out     (sel_out),
        .grant_a_out (grant_a_out),
        .grant_b_out (grant_b_out),
        .busy_out    (busy_out),
        .timeout_out (timeout_out)
    );

    always #5 clk_in = ~clk_in;

    // Model: owner 0 = nobody, 1 = A, 2 = B; held = granted cycles already completed.
    int m_owner = 0;
    int m_held  = 0;
    bit m_last_b = 1'b1;
    bit m_sel = 1'b0;
    bit m_to = 1'b0;

    always @(posedge clk_in) begin
        int  nxt;
        bit  mine, other, rel, forced;
        if (!rstn_in) begin
            m_owner = 0; m_held = 0; m_last_b = 1'b1; m_sel = 1'b0; m_to = 1'b0;
        end else begin
            rel = 1'b0; forced = 1'b0;
            if (m_owner == 0) begin
                if (req_a_in && req_b_in) nxt = m_last_b ? 1 : 2;
                else if (req_a_in)        nxt = 1;
                else if (req_b_in)        nxt = 2;
                else                      nxt = 0;
            end else begin
                m_held = m_held + 1;
                mine  = (m_owner == 1) ? req_a_in : req_b_in;
                other = (m_owner == 1) ? req_b_in : req_a_in;
                if (done_in || !mine) rel = 1'b1;
                else if (TO_EN && m_held >= MAX_HOLD) begin rel = 1'b1; forced = 1'b1; end
                if (!rel)       nxt = m_owner;
                else if (other) nxt = 3 - m_owner;
                else if (mine)  nxt = m_owner;
                else            nxt = 0;
            end
            if (nxt != 0 && (m_owner == 0 || rel)) begin
                m_held = 0;
                m_last_b = (nxt == 2);
            end
            if (nxt != 0) m_sel = (nxt == 2);
            m_to = forced;
            m_owner = nxt;
        end
    end

    task automatic chk(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b at t=%0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk_in) begin
        chk("grant_a", grant_a_out, m_owner == 1);
        chk("grant_b", grant_b_out, m_owner == 2);
        chk("sel",     sel_out,     m_sel);
        chk("busy",    busy_out,    m_owner != 0);
        chk("timeout", timeout_out, m_to);
        chk("no_overlap", grant_a_out && grant_b_out, 1'b0);
    end

    // Apply inputs, let one rising edge pass, return at the following falling edge.
    task automatic drive(input logic ra, input logic rb, input logic d, input logic rn);
        req_a_in = ra; req_b_in = rb; done_in = d; rstn_in = rn;
        @(negedge clk_in);
    endtask

    initial begin
        // Reset values, then tie goes to A, done hands over to B.
        drive(0, 0, 0, 0);
        chk("rst_sel", sel_out, 1'b0);
        chk("rst_busy", busy_out, 1'b0);
        chk("rst_gnt", grant_a_out | grant_b_out, 1'b0);
        chk("rst_to", timeout_out, 1'b0);
        drive(1, 1, 0, 1);
        chk("tie_first_a", grant_a_out, 1'b1);
        chk("tie_first_sel", sel_out, 1'b0);
        drive(1, 1, 0, 1);
        drive(1, 1, 1, 1);
        chk("handover_b", grant_b_out, 1'b1);
        chk("handover_sel", sel_out, 1'b1);

        // B alone, released at edge 4, sel held in IDLE; done ignored in IDLE.
        drive(0, 0, 0, 0);
        drive(0, 1, 0, 1);
        drive(0, 1, 0, 1);
        drive(0, 1, 0, 1);
        chk("b_held", grant_b_out, 1'b1);
        drive(0, 0, 1, 1);
        chk("idle_busy", busy_out, 1'b0);
        chk("idle_sel_held", sel_out, 1'b1);
        drive(0, 0, 1, 1);
        chk("idle_done_ignored", busy_out, 1'b0);

        // A drops its request with B waiting: direct hand-over.
        drive(1, 0, 0, 1);
        chk("a_alone", grant_a_out, 1'b1);
        drive(0, 1, 0, 1);
        chk("drop_to_b", grant_b_out, 1'b1);
        chk("drop_a_off", grant_a_out, 1'b0);

        // Reset mid-grant wins over requests; next tie grants A.
        drive(1, 1, 1, 0);
        chk("midrst_gnt", grant_a_out | grant_b_out, 1'b0);
        chk("midrst_sel", sel_out, 1'b0);
        drive(1, 1, 0, 1);
        chk("post_rst_tie_a", grant_a_out, 1'b1);

        // Hold limit: A holds four cycles, then forced over to B.
        drive(0, 0, 0, 0);
        drive(1, 1, 0, 1);
        drive(1, 1, 0, 1);
        drive(1, 1, 0, 1);
        drive(1, 1, 0, 1);
        chk("hold_a_c4", grant_a_out, 1'b1);
        drive(1, 1, 0, 1);
`ifdef ARB_TIMEOUT_EN
        chk("timeout_to_b", grant_b_out, 1'b1);
        chk("timeout_pulse", timeout_out, 1'b1);
        drive(1, 1, 0, 1);
        chk("timeout_one_cycle", timeout_out, 1'b0);
`else
        chk("no_timeout_a", grant_a_out, 1'b1);
        chk("no_timeout_pulse", timeout_out, 1'b0);
`endif

        // Randomized traffic, requests biased high so long holds occur.
        for (int i = 0; i < 4000; i++) begin
            drive($urandom_range(3, 0) != 0,
                  $urandom_range(3, 0) != 0,
                  $urandom_range(5, 0) == 0,
                  $urandom_range(99, 0) != 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mux_sel_arbiter.md
MUX_SEL_ARBITER -- requirements
Module: mux_sel_arbiter

Interface
REQ-001 Parameter: MAX_HOLD, 15, grant-hold limit in cycles (used only with ARB_TIMEOUT_EN; legal range 2..255).
REQ-002 Port: clk_in  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rstn_in  input  1  reset, synchronous, active-low.
REQ-004 Port: req_a_in  input  1  requester A wants the downstream 2:1 mux path (a_in side).
REQ-005 Port: req_b_in  input  1  requester B wants the downstream 2:1 mux path (b_in side).
REQ-006 Port: done_in  input  1  current owner finished its transfer; sampled only while a grant is held.
REQ-007 Port: sel_out  output  1  registered select for the downstream 2:1 mux; 0 = A, 1 = B.
REQ-008 Port: grant_a_out  output  1  registered grant to A.
REQ-009 Port: grant_b_out  output  1  registered grant to B.
REQ-010 Port: busy_out  output  1  grant_a_out OR grant_b_out.
REQ-011 Port: timeout_out  output  1  one-cycle pulse on forced release; constant 0 without ARB_TIMEOUT_EN.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, GNT_A, GNT_B; all outputs SHALL be registered.
REQ-013 grant_a_out SHALL be 1 only in GNT_A and grant_b_out only in GNT_B; the two grants SHALL never be 1 together.
REQ-014 sel_out SHALL be 0 in GNT_A, 1 in GNT_B, and hold the last granted side in IDLE so the mux output stays stable.
REQ-015 In IDLE, with only req_a_in=1 the FSM SHALL go to GNT_A on the next edge; with only req_b_in=1 it SHALL go to GNT_B.
REQ-016 In IDLE, with both requests at 1 the FSM SHALL grant the side not granted last (round-robin bit last_b).
REQ-017 Grant latency SHALL be one cycle: request sampled at edge N, grant visible after edge N.
REQ-018 A grant SHALL be released when done_in=1, or when the owner's req deasserts, at the sampling edge.
REQ-019 On release, if the other side requests, the FSM SHALL move directly to the other grant with no IDLE bubble.
REQ-020 On release, if only the releasing side still requests, the FSM SHALL re-grant the same side.
REQ-021 On release with no requests, the FSM SHALL return to IDLE.
REQ-022 last_b SHALL update on every grant entry: 1 for GNT_B, 0 for GNT_A.
REQ-023 done_in SHALL be ignored in IDLE.

Reset
REQ-024 With rstn_in=0 at a rising edge, the next state SHALL be: IDLE, sel_out=0, grants=0, busy_out=0, timeout_out=0, last_b=1 (A wins first tie), hold counter=0.
REQ-025 Reset SHALL take effect mid-grant and take priority over done_in, requests and timeout.

Configuration
REQ-026 Macro ARB_TIMEOUT_EN defined: a hold counter SHALL clear on grant entry and increment each granted cycle; if MAX_HOLD granted cycles pass without release, the grant SHALL be forcibly released per REQ-019..021, and timeout_out SHALL pulse for one cycle coincident with the first cycle of the resulting state.
REQ-027 Macro ARB_TIMEOUT_EN undefined: no counter SHALL be built, a grant SHALL be held indefinitely, and timeout_out SHALL be tied to 0.
REQ-028 A release by done_in in the same cycle as the timeout SHALL count as normal: no timeout_out pulse.

Verification
REQ-029 Reset, then req_a_in=req_b_in=1 at edge 1 -> after edge 1 grant_a_out=1, sel_out=0; done_in at edge 3 -> after edge 3 grant_b_out=1, sel_out=1.
REQ-030 Only req_b_in=1, done_in at edge 4, no further requests -> GNT_B for edges 1..4, then IDLE with sel_out held at 1 and busy_out=0.
REQ-031 GNT_A held, req_a_in drops with no done_in and req_b_in=1 -> grant_b_out=1 on the next edge; grants never overlap.
REQ-032 GNT_B held, rstn_in=0 for one edge -> all outputs at reset values after that edge; a later tie grants A.
REQ-033 ARB_TIMEOUT_EN with MAX_HOLD=4, req_a_in held, req_b_in=1, done_in=0 -> grant_a_out high for 4 cycles, then grant_b_out=1 with timeout_out=1 for exactly 1 cycle; without the macro grant_a_out stays high and timeout_out stays 0.
